// File: rtl/odd_seq_pkg.sv
// Shared types and constants for the odd-count stream checker.
package odd_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } state_t;

  localparam int STEP = 2;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; a clear coincident with an
// increment restarts the count at one so that event is not lost.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? W'(1) : '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/odd_seq_checker.sv
// Monitors an odd +2 count stream: acquires lock, flags parity/sequence
// errors and keeps a saturating error count.
module odd_seq_checker
  import odd_seq_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int LOCK_LEN = 4,
  parameter int MAX_MISS = 3,
  parameter int ERR_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] cnt_i,
  input  logic             valid_i,
  input  logic             err_clr_i,
  output logic             locked_o,
  output logic             err_o,
  output logic             par_err_o,
  output logic             wrap_o,
  output logic [WIDTH-1:0] expected_o,
  output logic [ERR_W-1:0] err_cnt_o
);

  localparam int RUN_W  = $clog2(LOCK_LEN + 1);
  localparam int MISS_W = $clog2(MAX_MISS + 1);

  state_t            state, state_nx;
  logic [RUN_W-1:0]  run, run_nx;
  logic [MISS_W-1:0] miss, miss_nx;
  logic [WIDTH-1:0]  expected_nx;
  logic              locked_nx, err_nx, par_nx, wrap_nx;
  logic              odd, match;

  assign odd   = cnt_i[0];
  assign match = (cnt_i == expected_o);

  // NOTE: every signal gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx    = state;
    run_nx      = run;
    miss_nx     = miss;
    expected_nx = expected_o;
    locked_nx   = locked_o;
    err_nx      = 1'b0;
    par_nx      = 1'b0;
    wrap_nx     = 1'b0;

    if (valid_i) begin
      unique case (state)
        IDLE: begin
          if (odd) begin
            expected_nx = cnt_i + WIDTH'(STEP);
            run_nx      = RUN_W'(1);
            state_nx    = ACQ;
          end else begin
            par_nx = 1'b1;
            err_nx = 1'b1;
          end
        end
        ACQ: begin
          if (match) begin
            run_nx      = run + 1'b1;
            expected_nx = expected_o + WIDTH'(STEP);
            if (run_nx == RUN_W'(LOCK_LEN)) begin
              state_nx  = LOCK;
              locked_nx = 1'b1;
            end
          end else if (odd) begin
            run_nx      = RUN_W'(1);
            expected_nx = cnt_i + WIDTH'(STEP);
          end else begin
            par_nx   = 1'b1;
            err_nx   = 1'b1;
            run_nx   = '0;
            state_nx = IDLE;
          end
        end
        LOCK: begin
          // Flywheel: the expectation advances whether or not the sample hit.
          expected_nx = expected_o + WIDTH'(STEP);
          if (match) begin
            miss_nx = '0;
            wrap_nx = (cnt_i == WIDTH'(1));
          end else begin
            err_nx  = 1'b1;
            par_nx  = ~odd;
            miss_nx = miss + 1'b1;
            if (miss_nx == MISS_W'(MAX_MISS)) begin
              state_nx  = IDLE;
              locked_nx = 1'b0;
              miss_nx   = '0;
              run_nx    = '0;
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      run        <= '0;
      miss       <= '0;
      expected_o <= '0;
      locked_o   <= 1'b0;
      err_o      <= 1'b0;
      par_err_o  <= 1'b0;
      wrap_o     <= 1'b0;
    end else begin
      state      <= state_nx;
      run        <= run_nx;
      miss       <= miss_nx;
      expected_o <= expected_nx;
      locked_o   <= locked_nx;
      err_o      <= err_nx;
      par_err_o  <= par_nx;
      wrap_o     <= wrap_nx;
    end
  end

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (err_clr_i),
    .inc   (err_nx),
    .count (err_cnt_o)
  );

endmodule
